// File: rtl/sargantana_icache_inval_unit.sv
// Valid-bit invalidation sequencer for the icache: full-array sweep on fence.i
// and in-order issue of buffered single-line invalidations from upper levels.
module sargantana_icache_inval_unit #(
  parameter int IDX_WIDTH      = 6,
  parameter int N_WAY          = 4,
  parameter int INV_FIFO_DEPTH = 4
) (
  input  logic                 clk_i,
  input  logic                 rst_i,
  input  logic                 flush_req_i,
  output logic                 flush_done_o,
  input  logic                 inval_valid_i,
  input  logic [IDX_WIDTH-1:0] inval_idx_i,
  output logic                 inval_ready_o,
  input  logic                 cache_busy_i,
  output logic                 inval_o,
  output logic [IDX_WIDTH-1:0] inval_idx_o,
  output logic [N_WAY-1:0]     inval_way_mask_o,
  output logic                 busy_o
);

  localparam int PTR_W = $clog2(INV_FIFO_DEPTH);
  localparam int CNT_W = PTR_W + 1;
  localparam logic [IDX_WIDTH-1:0] IDX_LAST = '1;
  localparam logic [CNT_W-1:0]     FIFO_FULL = CNT_W'(INV_FIFO_DEPTH);

  typedef enum logic [1:0] {IDLE, FLUSH, DONE} state_t;

  state_t               state, state_n;
  logic [IDX_WIDTH-1:0] cnt, cnt_n;

  logic [IDX_WIDTH-1:0] fifo_mem [INV_FIFO_DEPTH];
  logic [PTR_W-1:0]     rd_ptr, wr_ptr;
  logic [CNT_W-1:0]     count, count_n;
  logic                 empty;

  logic                 push, pop, clear;
  logic                 issue, done;
  logic [IDX_WIDTH-1:0] issue_idx;
  logic                 ready_n;

  assign empty = (count == '0);

  // Requests seen while sweeping are covered by the sweep itself, so they are
  // acknowledged but never stored; the DONE cycle already stores normally.
  assign clear = (state == IDLE) && flush_req_i;
  assign push  = inval_valid_i && inval_ready_o && (state != FLUSH) && !clear;
  assign pop   = (state == IDLE) && !flush_req_i && !empty && !cache_busy_i;

  always_comb begin
    state_n   = state;
    cnt_n     = cnt;
    issue     = 1'b0;
    issue_idx = '0;
    done      = 1'b0;
    case (state)
      IDLE: begin
        if (flush_req_i) begin
          state_n = FLUSH;
        end else if (pop) begin
          issue     = 1'b1;
          issue_idx = fifo_mem[rd_ptr];
        end
      end
      FLUSH: begin
        if (!cache_busy_i) begin
          issue     = 1'b1;
          issue_idx = cnt;
          cnt_n     = cnt + IDX_WIDTH'(1);
          if (cnt == IDX_LAST) state_n = DONE;
        end
      end
      DONE: begin
        done    = 1'b1;
        cnt_n   = '0;
        state_n = IDLE;
      end
      default: state_n = IDLE;
    endcase
  end

  always_comb begin
    count_n = count;
    if (clear) count_n = '0;
    else       count_n = count + CNT_W'(push) - CNT_W'(pop);
  end

  // Ready is registered from the next-cycle state and occupancy, so a full
  // FIFO never accepts even when a pop happens in the same cycle.
  assign ready_n = (state_n == FLUSH) || (count_n != FIFO_FULL);

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state            <= IDLE;
      cnt              <= '0;
      rd_ptr           <= '0;
      wr_ptr           <= '0;
      count            <= '0;
      flush_done_o     <= 1'b0;
      inval_o          <= 1'b0;
      inval_idx_o      <= '0;
      inval_way_mask_o <= '0;
      busy_o           <= 1'b0;
      inval_ready_o    <= 1'b1;
    end else begin
      state            <= state_n;
      cnt              <= cnt_n;
      count            <= count_n;
      flush_done_o     <= done;
      inval_o          <= issue;
      inval_way_mask_o <= issue ? '1 : '0;
      busy_o           <= (state != IDLE);
      inval_ready_o    <= ready_n;
      if (issue) inval_idx_o <= issue_idx;
      if (clear) begin
        rd_ptr <= '0;
        wr_ptr <= '0;
      end else begin
        if (push) wr_ptr <= wr_ptr + PTR_W'(1);
        if (pop)  rd_ptr <= rd_ptr + PTR_W'(1);
      end
    end
  end

  always_ff @(posedge clk_i) begin
    if (push) fifo_mem[wr_ptr] <= inval_idx_i;
  end

endmodule

// File: tb/tb_sargantana_icache_inval_unit.sv
// Directed bench for the icache invalidation unit: reset, sweeps with and
// without stalls, FIFO ordering/full, flush interaction and mid-sweep reset.
module tb_sargantana_icache_inval_unit;

  logic       clk = 1'b0;
  logic       rst_i, flush_req_i, flush_done_o;
  logic       inval_valid_i, inval_ready_o, cache_busy_i;
  logic [5:0] inval_idx_i, inval_idx_o;
  logic       inval_o, busy_o;
  logic [3:0] inval_way_mask_o;

  int n_chk  = 0;
  int n_fail = 0;

  always #5 clk = ~clk;

  sargantana_icache_inval_unit #(.IDX_WIDTH(6), .N_WAY(4), .INV_FIFO_DEPTH(4)) dut (
    .clk_i(clk), .rst_i(rst_i), .flush_req_i(flush_req_i), .flush_done_o(flush_done_o),
    .inval_valid_i(inval_valid_i), .inval_idx_i(inval_idx_i), .inval_ready_o(inval_ready_o),
    .cache_busy_i(cache_busy_i), .inval_o(inval_o), .inval_idx_o(inval_idx_o),
    .inval_way_mask_o(inval_way_mask_o), .busy_o(busy_o)
  );

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_chk++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic expect_out(input string tag, input logic e_inv, input logic [5:0] e_idx,
                            input logic e_done, input logic e_busy);
    chk({tag, ".inval"}, 32'(inval_o), 32'(e_inv));
    chk({tag, ".mask"}, 32'(inval_way_mask_o), e_inv ? 32'hf : 32'h0);
    chk({tag, ".done"}, 32'(flush_done_o), 32'(e_done));
    chk({tag, ".busy"}, 32'(busy_o), 32'(e_busy));
    if (e_inv) chk({tag, ".idx"}, 32'(inval_idx_o), 32'(e_idx));
  endtask

  initial begin
    logic [5:0] vals [4];
    vals[0] = 6'd5; vals[1] = 6'd9; vals[2] = 6'd3; vals[3] = 6'd7;

    rst_i = 1'b1; flush_req_i = 1'b0; inval_valid_i = 1'b0;
    inval_idx_i = '0; cache_busy_i = 1'b0;
    step(); step();
    expect_out("rst", 1'b0, 6'd0, 1'b0, 1'b0);
    chk("rst.idx", 32'(inval_idx_o), 32'd0);
    chk("rst.ready", 32'(inval_ready_o), 32'd1);
    rst_i = 1'b0;

    // idle, no requests
    for (int i = 0; i < 20; i++) begin
      step();
      expect_out("idle", 1'b0, 6'd0, 1'b0, 1'b0);
      chk("idle.ready", 32'(inval_ready_o), 32'd1);
    end

    // unstalled sweep
    flush_req_i = 1'b1;
    step();
    flush_req_i = 1'b0;
    expect_out("sw0.T", 1'b0, 6'd0, 1'b0, 1'b0);
    for (int i = 0; i < 64; i++) begin
      step();
      expect_out("sw0.issue", 1'b1, 6'(i), 1'b0, 1'b1);
      chk("sw0.ready", 32'(inval_ready_o), 32'd1);
    end
    step();
    expect_out("sw0.done", 1'b0, 6'd0, 1'b1, 1'b1);
    step();
    expect_out("sw0.after", 1'b0, 6'd0, 1'b0, 1'b0);

    // sweep stalled 3 cycles at idx 10
    flush_req_i = 1'b1;
    step();
    flush_req_i = 1'b0;
    for (int i = 0; i < 10; i++) begin
      step();
      expect_out("sw1.pre", 1'b1, 6'(i), 1'b0, 1'b1);
    end
    cache_busy_i = 1'b1;
    for (int i = 0; i < 3; i++) begin
      step();
      expect_out("sw1.stall", 1'b0, 6'd0, 1'b0, 1'b1);
    end
    cache_busy_i = 1'b0;
    for (int i = 10; i < 64; i++) begin
      step();
      expect_out("sw1.post", 1'b1, 6'(i), 1'b0, 1'b1);
    end
    step();
    expect_out("sw1.done", 1'b0, 6'd0, 1'b1, 1'b1);
    step();
    expect_out("sw1.after", 1'b0, 6'd0, 1'b0, 1'b0);

    // fill FIFO while array busy, 5th push refused, then drain in order
    cache_busy_i = 1'b1;
    for (int k = 0; k < 4; k++) begin
      inval_valid_i = 1'b1; inval_idx_i = vals[k];
      chk("fifo.ready", 32'(inval_ready_o), 32'd1);
      step();
      expect_out("fifo.hold", 1'b0, 6'd0, 1'b0, 1'b0);
    end
    inval_idx_i = 6'd11;
    chk("fifo.full", 32'(inval_ready_o), 32'd0);
    step();
    inval_valid_i = 1'b0; cache_busy_i = 1'b0;
    for (int k = 0; k < 4; k++) begin
      step();
      expect_out("fifo.drain", 1'b1, vals[k], 1'b0, 1'b0);
      chk("fifo.ready2", 32'(inval_ready_o), 32'd1);
    end
    step();
    expect_out("fifo.empty", 1'b0, 6'd0, 1'b0, 1'b0);

    // two queued entries discarded by flush; DONE-cycle request survives
    cache_busy_i = 1'b1;
    inval_valid_i = 1'b1; inval_idx_i = 6'd12; step();
    inval_idx_i = 6'd13; step();
    inval_valid_i = 1'b0;
    cache_busy_i = 1'b0; flush_req_i = 1'b1;
    step();
    flush_req_i = 1'b0;
    expect_out("fl.T", 1'b0, 6'd0, 1'b0, 1'b0);
    for (int i = 0; i < 64; i++) begin
      inval_valid_i = (i == 30); inval_idx_i = 6'd50;
      step();
      expect_out("fl.issue", 1'b1, 6'(i), 1'b0, 1'b1);
    end
    inval_valid_i = 1'b1; inval_idx_i = 6'd42;
    chk("fl.done_ready", 32'(inval_ready_o), 32'd1);
    step();
    inval_valid_i = 1'b0;
    expect_out("fl.done", 1'b0, 6'd0, 1'b1, 1'b1);
    step();
    expect_out("fl.post", 1'b1, 6'd42, 1'b0, 1'b0);
    step();
    expect_out("fl.none", 1'b0, 6'd0, 1'b0, 1'b0);

    // reset at sweep index 20 aborts; next flush restarts at 0
    flush_req_i = 1'b1;
    step();
    flush_req_i = 1'b0;
    for (int i = 0; i <= 20; i++) begin
      step();
      expect_out("ab.issue", 1'b1, 6'(i), 1'b0, 1'b1);
    end
    rst_i = 1'b1;
    step();
    rst_i = 1'b0;
    expect_out("ab.rst", 1'b0, 6'd0, 1'b0, 1'b0);
    chk("ab.rst.idx", 32'(inval_idx_o), 32'd0);
    chk("ab.rst.ready", 32'(inval_ready_o), 32'd1);
    for (int i = 0; i < 5; i++) begin
      step();
      expect_out("ab.quiet", 1'b0, 6'd0, 1'b0, 1'b0);
    end
    flush_req_i = 1'b1;
    step();
    flush_req_i = 1'b0;
    for (int i = 0; i < 64; i++) begin
      step();
      expect_out("ab.re", 1'b1, 6'(i), 1'b0, 1'b1);
    end
    step();
    expect_out("ab.done", 1'b0, 6'd0, 1'b1, 1'b1);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
